quad_node_expander: RTL

Quadrant-to-node fan-out engine for the NoC. It accepts one request naming a target quadrant and a payload, then emits one unicast descriptor per member node of that quadrant, in ascending node-id order, over a valid/ready interface. This is the inverse of the node-id-to-quadrant classification the routers use. It sits between a traffic source (broadcast/multicast generator) and the packet injector.

---
 rtl/quad_node_expander_if.sv | 36 +++
 rtl/quad_node_expander.sv | 128 ++++++++++++
 2 files changed

// File: rtl/quad_node_expander_if.sv
// Request/descriptor bundle between a fan-out source, quad_node_expander and the injector.
// Latency: none (wires only); timing is owned by the modules on either side.
// Backpressure: valid/ready on both the request side and the descriptor side.
//
// Ports (slave = expander side):
//   req_valid/req_ready/req_quad/req_src/req_payload : incoming fan-out request
//   out_valid/out_ready/out_dst/out_payload/out_last : outgoing unicast descriptors
//   empty_pulse                                      : request resolved to no destinations
interface quad_node_expander_if #(
    parameter int PAYLOAD_W = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_quad;
    logic [4:0]           req_src;
    logic [PAYLOAD_W-1:0] req_payload;

    logic                 out_valid;
    logic                 out_ready;
    logic [4:0]           out_dst;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 out_last;
    logic                 empty_pulse;

    // Traffic source / injector side.
    modport master (
        output req_valid, req_quad, req_src, req_payload, out_ready,
        input  req_ready, out_valid, out_dst, out_payload, out_last, empty_pulse
    );

    // Expander side.
    modport slave (
        input  req_valid, req_quad, req_src, req_payload, out_ready,
        output req_ready, out_valid, out_dst, out_payload, out_last, empty_pulse
    );
endinterface

// File: rtl/quad_node_expander.sv
// Expands one quadrant request into one unicast descriptor per member node, ascending id order.
// Latency: first descriptor in the cycle after accept, then one per cycle while out_ready is high.
// Backpressure: descriptors hold while out_ready is low; no request accepted until the fan-out ends.
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : quad_node_expander_if.slave (request in, descriptors out, empty_pulse)
module quad_node_expander #(
    parameter int NUM_NODES = 20,
    parameter int PAYLOAD_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    quad_node_expander_if.slave   bus
);

    // Fixed quadrant membership, one bit per node id.
    localparam logic [31:0] Q1_MASK = 32'h0003_3300; // 8,9,12,13,16,17
    localparam logic [31:0] Q2_MASK = 32'h0000_0033; // 0,1,4,5
    localparam logic [31:0] Q3_MASK = 32'hFFF0_00CC; // 2,3,6,7,20..31
    localparam logic [31:0] Q4_MASK = 32'h000C_CC00; // 10,11,14,15,18,19

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t               state;
    logic [31:0]          rem_mask;
    logic [PAYLOAD_W-1:0] payload_q;

    logic [31:0] range_mask;
    logic [31:0] quad_mask;
    logic [31:0] member_mask;
    logic [31:0] rem_next;

    function automatic logic [4:0] lowest_idx(input logic [31:0] m);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (m[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic single_bit(input logic [31:0] m);
        return (m != '0) && ((m & (m - 32'd1)) == '0);
    endfunction

    always_comb begin
        range_mask = '0;
        for (int i = 0; i < 32; i++) begin
            range_mask[i] = (i < NUM_NODES);
        end
    end

    always_comb begin
        quad_mask = '0;
        case (bus.req_quad)
            2'b00:   quad_mask = Q1_MASK;
            2'b01:   quad_mask = Q2_MASK;
            2'b10:   quad_mask = Q3_MASK;
            default: quad_mask = Q4_MASK;
        endcase
    end

    // A source outside the quadrant or out of range simply clears a bit that is already zero.
    assign member_mask = quad_mask & range_mask & ~(32'd1 << bus.req_src);

    // Remaining set after the current (lowest) destination is consumed.
    assign rem_next = rem_mask & (rem_mask - 32'd1);

    assign bus.out_payload = payload_q;

    // Descriptor outputs are precomputed from the next mask so they are all registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            rem_mask        <= '0;
            payload_q       <= '0;
            bus.empty_pulse <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_last    <= 1'b0;
            bus.out_dst     <= '0;
            bus.req_ready   <= 1'b1;
        end else begin
            bus.empty_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        payload_q <= bus.req_payload;
                        rem_mask  <= member_mask;
                        if (member_mask != '0) begin
                            state         <= BUSY;
                            bus.req_ready <= 1'b0;
                            bus.out_valid <= 1'b1;
                            bus.out_dst   <= lowest_idx(member_mask);
                            bus.out_last  <= single_bit(member_mask);
                        end else begin
                            bus.empty_pulse <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (bus.out_ready) begin
                        rem_mask <= rem_next;
                        if (bus.out_last) begin
                            // req_ready rises only after this edge: one bubble between requests.
                            state         <= IDLE;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.req_ready <= 1'b1;
                        end else begin
                            bus.out_dst  <= lowest_idx(rem_next);
                            bus.out_last <= single_bit(rem_next);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
